param_cache: RTL
================

// Module: param_cache
// PURPOSE
// - Parametrised direct-mapped, write-through, no-write-allocate data cache between core LSU and data memory.
// - Both sides use the core memory protocol (req/gnt/rvalid); drop-in successor to the fixed-size single-line cache.
// - Adds configurable depth, byte-enable write merging, a flush input and optional hit/miss counters.
// PARAMETERS
// - ADDR_WIDTH   16  byte address width
// - DATA_WIDTH   32  word width; multiple of 8; OFFSET = log2(DATA_WIDTH/8)
// - INDEX_WIDTH  4   log2(number of lines); one word per line; TAG = ADDR_WIDTH-INDEX_WIDTH-OFFSET (>=1)
// PORTS
// - clk               in   1             clock, rising edge
// - rst_n             in   1             asynchronous active-low reset
// - flush_i           in   1             pulse: invalidate all lines
// - in_data_req_i     in   1             core request
// - in_data_gnt_o     out  1             request accepted
// - in_data_rvalid_o  out  1             response valid (reads and writes)
// - in_data_addr_i    in   ADDR_WIDTH    byte address (offset bits ignored)
// - in_data_we_i      in   1             1=write
// - in_data_be_i      in   DATA_WIDTH/8  byte enables
// - in_data_rdata_o   out  DATA_WIDTH    read data, valid with rvalid
// - in_data_wdata_i   in   DATA_WIDTH    write data
// - out_data_req_o    out  1             memory request
// - out_data_gnt_i    in   1             memory grant
// - out_data_rvalid_i in   1             memory response valid
// - out_data_addr_o   out  ADDR_WIDTH    memory address
// - out_data_we_o     out  1             memory write
// - out_data_be_o     out  DATA_WIDTH/8  memory byte enables (all-ones for refill reads)
// - out_data_rdata_i  in   DATA_WIDTH    memory read data
// - out_data_wdata_o  out  DATA_WIDTH    memory write data
// BEHAVIOUR
// - Reset: all valid bits 0, state IDLE; all outputs 0 (rdata/addr/wdata/be 0).
// - States IDLE, HIT_RSP, MEM_REQ, MEM_WAIT, FLUSH. One outstanding core request.
// - IDLE: in_data_gnt_o = in_data_req_i & ~flush_pending (combinational). On gnt latch addr/we/be/wdata.
//   read hit (valid & tag match) -> HIT_RSP; read miss or any write -> MEM_REQ.
// - HIT_RSP: rvalid=1, rdata=line data, 1 cycle -> IDLE. Read-hit latency: rvalid 1 cycle after gnt.
// - MEM_REQ: out_req=1 with latched addr; read: we=0, be all-ones; write: we=1, be/wdata from core.
//   Hold all out_* stable until out_gnt_i, then -> MEM_WAIT (out_req drops same edge).
// - MEM_WAIT: on out_rvalid_i: rvalid to core that cycle (combinational pass-through), rdata=out_rdata_i for reads;
//   read miss: write line, set valid, store tag; write: if line hit, merge wdata bytes where be=1, else no change. -> IDLE.
// - Core write responses carry rdata=0. in_data_gnt_o=0 in every state other than IDLE.
// - flush_i: in IDLE with no gnt this cycle -> FLUSH; otherwise latched as flush_pending, taken on return to IDLE
//   (blocks new gnt while pending). FLUSH: clear all valid bits in one cycle -> IDLE. flush_i while FLUSH/pending: absorbed.
// - Simultaneous flush_i and in_data_req_i in IDLE: flush wins, gnt withheld that cycle.
// - Refill in MEM_WAIT coinciding with flush_pending: refill written, then flushed.
// - Reset mid-transaction: FSM to IDLE, valids cleared, out_req dropped immediately; memory-side rvalid after reset ignored.
// - Index = addr[OFFSET +: INDEX_WIDTH]; tag = addr[ADDR_WIDTH-1 -: TAG]. Aliasing lines replace on read miss.
// CONFIGURATION
// - CACHE_STATS_EN defined: adds ports hit_count_o, miss_count_o (out, 32): count read hits / read misses at gnt,
//   saturating at 2^32-1, cleared by reset only (not flush). Writes counted in neither.
// - Undefined: ports and counters absent; all other behaviour identical.
// TESTING
// - Read 0x0040 cold, mem returns 0xDEADBEEF after 2 cycles -> one out_req, rvalid+0xDEADBEEF with out_rvalid.
// - Re-read 0x0040 -> no out_req, gnt same cycle, rvalid+0xDEADBEEF next cycle; CACHE_STATS_EN: hit=1, miss=1.
// - Write 0x0040 be=0b0011 wdata=0x00001234 -> out we=1 be=0b0011; then read -> 0xDEAD1234 from cache.
// - Read 0x0440 (same index, other tag) then 0x0040 -> both miss; 0x0040 refetched from memory.
// - flush_i while in MEM_WAIT -> refill completes, next read of that address misses; req+flush same cycle -> no gnt.
// - Assert rst_n=0 in MEM_REQ -> out_req 0 immediately, previously cached address misses after reset.

Source files
------------

// File: rtl/param_cache.sv
// param_cache: direct-mapped, write-through, no-write-allocate data cache.
// Define CACHE_STATS_EN to add saturating read hit/miss counters.
module param_cache #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_i,
  input  logic                    in_data_req_i,
  output logic                    in_data_gnt_o,
  output logic                    in_data_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]   in_data_addr_i,
  input  logic                    in_data_we_i,
  input  logic [DATA_WIDTH/8-1:0] in_data_be_i,
  output logic [DATA_WIDTH-1:0]   in_data_rdata_o,
  input  logic [DATA_WIDTH-1:0]   in_data_wdata_i,
  output logic                    out_data_req_o,
  input  logic                    out_data_gnt_i,
  input  logic                    out_data_rvalid_i,
  output logic [ADDR_WIDTH-1:0]   out_data_addr_o,
  output logic                    out_data_we_o,
  output logic [DATA_WIDTH/8-1:0] out_data_be_o,
  input  logic [DATA_WIDTH-1:0]   out_data_rdata_i,
  output logic [DATA_WIDTH-1:0]   out_data_wdata_o
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]             hit_count_o,
  output logic [31:0]             miss_count_o
`endif
);

  localparam int BE_W   = DATA_WIDTH / 8;
  localparam int OFFSET = $clog2(BE_W);
  localparam int TAG_W  = ADDR_WIDTH - INDEX_WIDTH - OFFSET;
  localparam int LINES  = 1 << INDEX_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_HIT_RSP, S_MEM_REQ, S_MEM_WAIT, S_FLUSH
  } state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_we;
  logic [BE_W-1:0]         r_be;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic                    r_flush_pend;
  logic [LINES-1:0]        r_valid;
  logic [DATA_WIDTH-1:0]   r_data [LINES];
  logic [TAG_W-1:0]        r_tag  [LINES];

  logic [INDEX_WIDTH-1:0]  w_in_idx;
  logic [TAG_W-1:0]        w_in_tag;
  logic                    w_in_hit;
  logic [INDEX_WIDTH-1:0]  w_idx;
  logic [TAG_W-1:0]        w_tag;
  logic                    w_hit;
  logic                    w_flush;
  logic                    w_gnt;
  logic                    w_mem_rsp;
  logic                    w_hit_rsp;
  logic [DATA_WIDTH-1:0]   w_merged;

  assign w_in_idx  = in_data_addr_i[OFFSET +: INDEX_WIDTH];
  assign w_in_tag  = in_data_addr_i[ADDR_WIDTH-1 -: TAG_W];
  assign w_in_hit  = r_valid[w_in_idx] && (r_tag[w_in_idx] == w_in_tag);
  assign w_idx     = r_addr[OFFSET +: INDEX_WIDTH];
  assign w_tag     = r_addr[ADDR_WIDTH-1 -: TAG_W];
  assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_flush   = flush_i | r_flush_pend;
  assign w_gnt     = (r_state == S_IDLE) & in_data_req_i & ~w_flush;
  assign w_mem_rsp = (r_state == S_MEM_WAIT) & out_data_rvalid_i;
  assign w_hit_rsp = (r_state == S_HIT_RSP);

  always_comb begin
    w_merged = r_data[w_idx];
    for (int b = 0; b < BE_W; b++)
      if (r_be[b]) w_merged[8*b +: 8] = r_wdata[8*b +: 8];
  end

  assign in_data_gnt_o    = w_gnt;
  assign in_data_rvalid_o = w_hit_rsp | w_mem_rsp;
  assign in_data_rdata_o  = w_hit_rsp ? r_data[w_idx] :
                            (w_mem_rsp & ~r_we) ? out_data_rdata_i : '0;

  // Memory-side fields are gated by req so they idle at zero.
  assign out_data_req_o   = (r_state == S_MEM_REQ);
  assign out_data_addr_o  = out_data_req_o ? r_addr : '0;
  assign out_data_we_o    = out_data_req_o & r_we;
  assign out_data_be_o    = !out_data_req_o ? '0 : (r_we ? r_be : '1);
  assign out_data_wdata_o = (out_data_req_o & r_we) ? r_wdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_we         <= 1'b0;
      r_be         <= '0;
      r_wdata      <= '0;
      r_flush_pend <= 1'b0;
      r_valid      <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_flush) begin
            r_flush_pend <= 1'b0;
            r_state      <= S_FLUSH;
          end else if (in_data_req_i) begin
            r_addr  <= in_data_addr_i;
            r_we    <= in_data_we_i;
            r_be    <= in_data_be_i;
            r_wdata <= in_data_wdata_i;
            r_state <= (!in_data_we_i && w_in_hit) ? S_HIT_RSP : S_MEM_REQ;
          end
        end
        S_HIT_RSP: begin
          if (flush_i) r_flush_pend <= 1'b1;
          r_state <= S_IDLE;
        end
        S_MEM_REQ: begin
          if (flush_i) r_flush_pend <= 1'b1;
          if (out_data_gnt_i) r_state <= S_MEM_WAIT;
        end
        S_MEM_WAIT: begin
          if (flush_i) r_flush_pend <= 1'b1;
          if (out_data_rvalid_i) begin
            if (!r_we) r_valid[w_idx] <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        S_FLUSH: begin
          r_valid <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_rsp) begin
      if (!r_we) begin
        r_data[w_idx] <= out_data_rdata_i;
        r_tag[w_idx]  <= w_tag;
      end else if (w_hit) begin
        r_data[w_idx] <= w_merged;
      end
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (w_gnt && !in_data_we_i) begin
      if (w_in_hit) begin
        if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 32'd1;
      end else begin
        if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign hit_count_o  = r_hit_cnt;
  assign miss_count_o = r_miss_cnt;
`endif

endmodule
